// File: rtl/pair_symbol_encoder.sv
// Serializes a parallel word onto x1/x2 as two-cycle symbols so that a downstream
// equality pulse detector reproduces each '1' bit as a single high y_out cycle.
module pair_symbol_encoder #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             x1,
  output logic             x2
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SLOT_A,
    SLOT_B
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_next;
  logic [CW-1:0]    bit_cnt;
  logic             phase;

  // The bit on the wire is always taken from the head of the shift register.
  function automatic logic head(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  always_comb begin
    shreg_next = MSB_FIRST ? (shreg << 1) : (shreg >> 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      phase   <= 1'b0;
      x1      <= 1'b1;
      x2      <= 1'b0;
      ready   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            state   <= SLOT_A;
            shreg   <= data_in;
            bit_cnt <= '0;
            phase   <= 1'b0;
            ready   <= 1'b0;
            busy    <= 1'b1;
            // First bit goes out at phase 0: equal 00 for '1', differ 10 for '0'.
            {x1, x2} <= head(data_in) ? 2'b00 : 2'b10;
          end else begin
            {x1, x2} <= 2'b10;
          end
        end
        SLOT_A: begin
          state    <= SLOT_B;
          {x1, x2} <= {~phase, phase};
        end
        SLOT_B: begin
          if (bit_cnt == LAST_BIT) begin
            state    <= IDLE;
            ready    <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b1;
            {x1, x2} <= 2'b10;
          end else begin
            state    <= SLOT_A;
            shreg    <= shreg_next;
            bit_cnt  <= bit_cnt + 1'b1;
            phase    <= ~phase;
            // Symbol for the next bit uses the toggled phase.
            {x1, x2} <= head(shreg_next) ? {~phase, ~phase} : {phase, ~phase};
          end
        end
        default: begin
          state    <= IDLE;
          ready    <= 1'b1;
          busy     <= 1'b0;
          {x1, x2} <= 2'b10;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pair_symbol_encoder.sv
// Randomized scoreboard bench: the driver queues expected symbols per accepted frame,
// the monitor pops them each cycle and also decodes the word through a detector model.
module tb_pair_symbol_encoder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] data_in = '0;
  logic         load = 1'b0;
  logic         ready, busy, done, x1, x2;
  logic         y;

  int compared = 0;
  int mismatched = 0;

  logic [1:0]   sym_q[$];
  logic [W-1:0] word_q[$];

  pair_symbol_encoder #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .load(load),
    .ready(ready), .busy(busy), .done(done), .x1(x1), .x2(x2)
  );

  always #5 clk = ~clk;

  // Equality detector model: y is high the cycle after x1==x2.
  always @(posedge clk) y <= rst ? 1'b0 : (x1 == x2);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected wire symbols for one frame, straight from the symbol rules.
  task automatic push_frame(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) begin
      logic b, p;
      b = w[W-1-i];
      p = (i % 2) == 1;
      sym_q.push_back(b ? {p, p} : {~p, p});
      sym_q.push_back({~p, p});
    end
    word_q.push_back(w);
    $display("load accepted: word %02h", w);
  endtask

  task automatic cycle(input logic r, input logic l, input logic [W-1:0] d);
    logic rdy_pre;
    rst = r; load = l; data_in = d;
    rdy_pre = ready;
    @(posedge clk);
    if (r) begin
      sym_q.delete();
      word_q.delete();
    end else if (l && rdy_pre) begin
      push_frame(d);
    end
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 4 * W) begin
      cycle(1'b0, 1'b0, '0);
      n++;
    end
    chk("ready_timeout", {31'd0, ready}, 32'd1);
  endtask

  // Load a word, then keep poking load with junk while the frame is in flight.
  task automatic send(input logic [W-1:0] w, input int noise);
    wait_ready();
    cycle(1'b0, 1'b1, w);
    for (int i = 0; i < noise; i++) cycle(1'b0, 1'($urandom), W'($urandom));
  endtask

  // Monitor
  initial begin
    int           idx = 0;
    logic         exp_done = 1'b0;
    logic         chk_reset = 1'b0;
    logic         exp_busy;
    logic [1:0]   s;
    logic [W-1:0] dec = '0;
    logic [W-1:0] wexp;
    forever begin
      @(negedge clk);
      if (chk_reset) begin
        chk("rst_x1x2", {30'd0, x1, x2}, 32'h2);
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk_reset = 1'b0;
      end else begin
        chk("done", {31'd0, done}, {31'd0, exp_done});
        if (exp_done) begin
          if (word_q.size() == 0) chk("word_q_empty", 32'd1, 32'd0);
          else begin
            wexp = word_q.pop_front();
            chk("decoded_word", {24'd0, dec}, {24'd0, wexp});
            $display("frame done: decoded %02h expected %02h", dec, wexp);
          end
        end
        exp_done = 1'b0;
        exp_busy = sym_q.size() != 0;
        chk("busy", {31'd0, busy}, {31'd0, exp_busy});
        chk("ready", {31'd0, ready}, {31'd0, ~exp_busy});
        if (exp_busy) begin
          s = sym_q.pop_front();
          chk("x1x2", {30'd0, x1, x2}, {30'd0, s});
          if (idx % 2 == 1) dec = {dec[W-2:0], y};
          else chk("y_low_in_slot_a", {31'd0, y}, 32'd0);
          idx++;
          if (idx == 2 * W) begin
            idx = 0;
            exp_done = 1'b1;
          end
        end else begin
          chk("idle_x1x2", {30'd0, x1, x2}, 32'h2);
          chk("idle_y", {31'd0, y}, 32'd0);
        end
      end
      if (rst) begin
        idx = 0;
        exp_done = 1'b0;
        chk_reset = 1'b1;
      end
    end
  end

  // Stimulus
  initial begin
    cycle(1'b1, 1'b0, '0);
    cycle(1'b1, 1'b0, '0);
    send(8'hA5, 15);
    send(8'h00, 15);
    send(8'hFF, 15);
    for (int f = 0; f < 12; f++) begin
      send(W'($urandom), 15);
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) cycle(1'b0, 1'b0, '0);
    end
    // Abort during bit 3, with load asserted on the reset edge.
    send(8'h3C, 6);
    cycle(1'b1, 1'b1, 8'hC3);
    cycle(1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, '0);
    for (int f = 0; f < 6; f++) send(W'($urandom), 15);
    wait_ready();
    repeat (3) cycle(1'b0, 1'b0, '0);
    chk("sym_q_drained", sym_q.size(), 32'd0);
    chk("word_q_drained", word_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
